// File: rtl/fnd_pkg.sv
// Shared types and widths for the 4-digit FND scan controller.
package fnd_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;
    localparam int BCD_W      = 4;
    localparam int VALUE_W    = NUM_DIGITS * BCD_W;

    function automatic logic [BCD_W-1:0] nibble_of(
        input logic [VALUE_W-1:0] v,
        input logic [DIGIT_W-1:0] d
    );
        return v[{d, 2'b00} +: BCD_W];
    endfunction

`ifdef FND_LZB_EN
    // Digit d is a leading zero when it and every higher nibble are 0.
    function automatic logic is_leading_zero(
        input logic [VALUE_W-1:0] v,
        input logic [DIGIT_W-1:0] d
    );
        logic lz;
        unique case (d)
            2'd1:    lz = (v[15:4] == '0);
            2'd2:    lz = (v[15:8] == '0);
            2'd3:    lz = (v[15:12] == '0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction
`endif

endpackage

// File: rtl/fnd_slot_timer.sv
// Digit-slot counter: counts 0..CLK_DIV-1 and flags the blank end and slot end.
module fnd_slot_timer #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic terminal,
    output logic blank_end
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign terminal  = (count == CNT_W'(CLK_DIV - 1));
    assign blank_end = (count == CNT_W'(BLANK_CYCLES - 1));

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND time-multiplexing sequencer with per-slot blanking.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
import fnd_pkg::*;

module fnd_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Enable,
    input  logic                 i_Load,
    input  logic [VALUE_W-1:0]   i_Value,
    output logic                 o_Pending,
    output logic [DIGIT_W-1:0]   o_DigitSelect,
    output logic                 o_Blank,
    output logic [BCD_W-1:0]     o_BCD,
    output logic                 o_FrameTick
);

    state_t               state;
    state_t               state_next;
    logic [DIGIT_W-1:0]   digit;
    logic [DIGIT_W-1:0]   digit_next;
    logic [VALUE_W-1:0]   shadow;
    logic [VALUE_W-1:0]   shadow_next;
    logic [VALUE_W-1:0]   display;
    logic [VALUE_W-1:0]   display_next;
    logic                 pending_next;
    logic                 blank_next;
    logic [BCD_W-1:0]     bcd_next;
    logic                 terminal;
    logic                 blank_end;
    logic                 clear;
    logic                 wrap;
    logic                 window;

    assign clear = (state == OFF) || !i_Enable;

    fnd_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (i_Clk),
        .reset     (i_Reset),
        .clear     (clear),
        .terminal  (terminal),
        .blank_end (blank_end)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= OFF;
            digit <= '0;
        end else begin
            state <= state_next;
            digit <= digit_next;
        end
    end

    always_comb begin
        state_next = state;
        digit_next = digit;
        unique case (state)
            OFF: begin
                if (i_Enable) state_next = BLANK;
            end
            BLANK: begin
                if (!i_Enable) begin
                    state_next = OFF;
                    digit_next = '0;
                end else if (blank_end) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (!i_Enable) begin
                    state_next = OFF;
                    digit_next = '0;
                end else if (terminal) begin
                    state_next = BLANK;
                    digit_next = digit + 1'b1;
                end
            end
            default: begin
                state_next = OFF;
                digit_next = '0;
            end
        endcase
    end

    // Commits land only at frame boundaries or while dark, so a frame never tears.
    assign wrap   = (state == SHOW) && i_Enable && terminal && (digit == 2'd3);
    assign window = wrap || (state == OFF);

    always_comb begin
        shadow_next  = shadow;
        display_next = display;
        pending_next = o_Pending;
        if (i_Load) begin
            shadow_next = i_Value;
            if (window) begin
                display_next = i_Value;
                pending_next = 1'b0;
            end else begin
                pending_next = 1'b1;
            end
        end else if (window && o_Pending) begin
            display_next = shadow;
            pending_next = 1'b0;
        end
`ifdef FND_LZB_EN
        blank_next = (state_next != SHOW)
                   || is_leading_zero(display_next, digit_next);
`else
        blank_next = (state_next != SHOW);
`endif
        bcd_next = nibble_of(display_next, digit_next);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            shadow      <= '0;
            display     <= '0;
            o_Pending   <= 1'b0;
            o_Blank     <= 1'b1;
            o_BCD       <= '0;
            o_FrameTick <= 1'b0;
        end else begin
            shadow      <= shadow_next;
            display     <= display_next;
            o_Pending   <= pending_next;
            o_Blank     <= blank_next;
            o_BCD       <= bcd_next;
            o_FrameTick <= wrap;
        end
    end

    assign o_DigitSelect = digit;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: directed table, leading-zero sequences, random run.
module tb_fnd_scan_controller;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] val = '0;
    logic        pending;
    logic [1:0]  dsel;
    logic        blank;
    logic [3:0]  bcd;
    logic        tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Enable      (en),
        .i_Load        (load),
        .i_Value       (val),
        .o_Pending     (pending),
        .o_DigitSelect (dsel),
        .o_Blank       (blank),
        .o_BCD         (bcd),
        .o_FrameTick   (tick)
    );

    // Reference: scanning time t since enable; digit and phase follow by division.
    bit          m_on = 1'b0;
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shad = '0;
    bit          m_pend = 1'b0;
    bit          m_tick = 1'b0;

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v >> (4 * k);
        return s[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit wrap;
        bit win;
        if (rst) begin
            m_on = 0; m_t = 0; m_disp = '0; m_shad = '0;
            m_pend = 0; m_tick = 0;
        end else begin
            wrap = m_on && en && (m_t % FRAME == FRAME - 1);
            win  = wrap || !m_on;
            m_tick = wrap;
            if (load) begin
                m_shad = val;
                if (win) begin
                    m_disp = val;
                    m_pend = 0;
                end else begin
                    m_pend = 1;
                end
            end else if (win && m_pend) begin
                m_disp = m_shad;
                m_pend = 0;
            end
            if (!en) begin
                m_on = 0; m_t = 0;
            end else if (m_on) begin
                m_t++;
            end else begin
                m_on = 1; m_t = 0;
            end
        end
    endtask

    task automatic model_check();
        int d;
        bit b;
        logic [15:0] hi;
        d = m_on ? (m_t / CLK_DIV) % 4 : 0;
        b = !m_on || (m_t % CLK_DIV) < BLANK_CYCLES;
        hi = m_disp >> (4 * d);
`ifdef FND_LZB_EN
        if (d > 0 && hi == 16'h0) b = 1;
`endif
        check("m_pending", pending, m_pend);
        check("m_digit", dsel, d);
        check("m_blank", blank, b);
        check("m_tick", tick, m_tick);
        if (!b) check("m_bcd", bcd, nib(m_disp, d));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          load;
        logic [15:0] val;
        int          n;
        bit          pend;
        int          dsel;
        bit          blank;
        bit          chk_bcd;
        logic [3:0]  bcd;
        bit          tick;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input bit l,
                       input logic [15:0] v, input int n, input bit p,
                       input int d, input bit b, input bit cb,
                       input logic [3:0] c, input bit t);
        vec_t x;
        x = '{r, e, l, v, n, p, d, b, cb, c, t};
        tbl.push_back(x);
    endtask

    task automatic lzb_seq(input logic [15:0] v, input bit [3:0] mask);
        rst = 1; en = 0; load = 0;
        cycle();
        rst = 0; load = 1; val = v;
        cycle();
        load = 0; en = 1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            repeat (k == 0 ? 4 : 8) cycle();
            check($sformatf("lzb_%0h_d%0d_blank", v, k), blank, mask[k]);
            if (!mask[k]) check($sformatf("lzb_%0h_d%0d_bcd", v, k), bcd, nib(v, k));
        end
    endtask

    initial begin
        // rst en ld val n | pend dsel blank chk_bcd bcd tick
        add(1, 0, 0, 16'h0000,  2, 0, 0, 1, 1, 4'h0, 0);
        add(0, 0, 1, 16'h1234,  1, 0, 0, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  1, 0, 0, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  2, 0, 0, 0, 1, 4'h4, 0);
        add(0, 1, 0, 16'h0000,  5, 0, 0, 0, 1, 4'h4, 0);
        add(0, 1, 0, 16'h0000,  1, 0, 1, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  2, 0, 1, 0, 1, 4'h3, 0);
        add(0, 1, 1, 16'h5678,  1, 1, 1, 0, 1, 4'h3, 0);
        add(0, 1, 0, 16'h0000,  8, 1, 2, 0, 1, 4'h2, 0);
        add(0, 1, 0, 16'h0000,  8, 1, 3, 0, 1, 4'h1, 0);
        add(0, 1, 0, 16'h0000,  4, 1, 3, 0, 1, 4'h1, 0);
        add(0, 1, 0, 16'h0000,  1, 0, 0, 1, 0, 4'h0, 1);
        add(0, 1, 0, 16'h0000,  2, 0, 0, 0, 1, 4'h8, 0);
        add(0, 1, 0, 16'h0000, 29, 0, 3, 0, 1, 4'h5, 0);
        add(0, 1, 1, 16'h9999,  1, 0, 0, 1, 0, 4'h0, 1);
        add(0, 1, 0, 16'h0000,  2, 0, 0, 0, 1, 4'h9, 0);
        add(0, 1, 0, 16'h0000, 16, 0, 2, 0, 1, 4'h9, 0);
        add(0, 0, 0, 16'h0000,  1, 0, 0, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  1, 0, 0, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  1, 0, 0, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  1, 0, 0, 0, 1, 4'h9, 0);
        add(0, 1, 1, 16'h1111,  1, 1, 0, 0, 1, 4'h9, 0);
        add(0, 1, 0, 16'h0000,  2, 1, 0, 0, 1, 4'h9, 0);
        add(1, 1, 0, 16'h0000,  1, 0, 0, 1, 1, 4'h0, 0);
        add(1, 1, 1, 16'hABCD,  1, 0, 0, 1, 1, 4'h0, 0);
        add(0, 0, 0, 16'h0000,  1, 0, 0, 1, 0, 4'h0, 0);
        add(0, 1, 0, 16'h0000,  3, 0, 0, 0, 1, 4'h0, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            val = tbl[i].val;
            for (int j = 0; j < tbl[i].n; j++) begin
                load = (j == 0) ? tbl[i].load : 1'b0;
                cycle();
            end
            load = 0;
            check($sformatf("row%0d_pending", i), pending, tbl[i].pend);
            check($sformatf("row%0d_digit", i), dsel, tbl[i].dsel);
            check($sformatf("row%0d_blank", i), blank, tbl[i].blank);
            check($sformatf("row%0d_tick", i), tick, tbl[i].tick);
            if (tbl[i].chk_bcd)
                check($sformatf("row%0d_bcd", i), bcd, tbl[i].bcd);
        end

`ifdef FND_LZB_EN
        lzb_seq(16'h0042, 4'b1100);
        lzb_seq(16'h0000, 4'b1110);
`else
        lzb_seq(16'h0042, 4'b0000);
        lzb_seq(16'h0000, 4'b0000);
`endif

        rst = 0; en = 1; load = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 400 == 0);
            if (en && $urandom % 90 == 0) en = 0;
            else if (!en && $urandom % 4 == 0) en = 1;
            load = ($urandom % 14 == 0);
            if ($urandom % 3 == 0) val = {8'h00, 8'($urandom)};
            else val = 16'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
